// File: rtl/mnist_run_ctrl.sv
// Run sequencer for the CNN accelerator: Avalon-MM register front end, start/done handshake,
// latency counter, timeout and abort. Define MNIST_RUN_CTRL_IRQ_EN to add the irq output and CTRL.irq_en.
module mnist_run_ctrl #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_RST = 1000000,
    parameter int CLR_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        eng_start,
    input  logic        eng_done,
    output logic        eng_clear
`ifdef MNIST_RUN_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       CLR_LAST     = 8'(CLR_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_INIT = 32'(TIMEOUT_RST);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   run_cnt_reg, run_cnt_next;
    logic [CNT_W-1:0]   last_reg, last_next;
    logic [31:0]        timeout_reg, timeout_next;
    logic [7:0]         clr_cnt_reg, clr_cnt_next;
    logic [2:0]         sticky_reg, sticky_next;   // {aborted, timeout, done}
    logic [2:0]         sticky_set;
    logic               sticky_start_clr;
    logic [31:0]        readdata_reg, readdata_next;
    logic               irq_en;

    logic               wr_en, wr_ctrl, wr_status, wr_timeout;
    logic               start_cmd, abort_cmd;
    logic [CNT_W-1:0]   cnt_inc;
    logic [32:0]        run_plus;
    logic               limit_hit;

    assign wr_en      = chipselect & ~write_n;
    assign wr_ctrl    = wr_en && (address == 2'd0);
    assign wr_status  = wr_en && (address == 2'd1);
    assign wr_timeout = wr_en && (address == 2'd3);
    assign start_cmd  = wr_ctrl & writedata[0];
    assign abort_cmd  = wr_ctrl & writedata[1];

    // The limit is compared against the unsaturated count so a saturated run never fires late.
    assign cnt_inc   = (run_cnt_reg == CNT_MAX) ? run_cnt_reg : run_cnt_reg + CNT_ONE;
    assign run_plus  = 33'(run_cnt_reg) + 33'd1;
    assign limit_hit = (timeout_reg != 32'd0) && (run_plus == {1'b0, timeout_reg});

    always_comb begin
        state_next       = state_reg;
        run_cnt_next     = run_cnt_reg;
        last_next        = last_reg;
        clr_cnt_next     = clr_cnt_reg;
        sticky_set       = 3'b000;
        sticky_start_clr = 1'b0;
        eng_start        = 1'b0;
        eng_clear        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_cmd) begin
                    state_next       = LAUNCH;
                    run_cnt_next     = '0;
                    sticky_start_clr = 1'b1;
                end
            end
            LAUNCH: begin
                eng_start  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (eng_done) begin
                    last_next     = cnt_inc;
                    sticky_set[0] = 1'b1;
                    state_next    = IDLE;
                end else if (abort_cmd) begin
                    last_next     = cnt_inc;
                    sticky_set[2] = 1'b1;
                    clr_cnt_next  = 8'd0;
                    state_next    = FLUSH;
                end else if (limit_hit) begin
                    last_next     = cnt_inc;
                    sticky_set[1] = 1'b1;
                    clr_cnt_next  = 8'd0;
                    state_next    = FLUSH;
                end else begin
                    run_cnt_next  = cnt_inc;
                end
            end
            FLUSH: begin
                eng_clear = 1'b1;
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = IDLE;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A set in the same cycle as a W1C or start clear wins.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sticky
            assign sticky_next[gi] = sticky_set[gi] |
                (sticky_reg[gi] & ~sticky_start_clr & ~(wr_status & writedata[gi + 1]));
        end
    endgenerate

    assign timeout_next = wr_timeout ? writedata : timeout_reg;

    always_comb begin
        readdata_next = 32'd0;
        case (address)
            2'd0:    readdata_next = {23'd0, irq_en, 8'd0};
            2'd1:    readdata_next = {27'd0, eng_done, sticky_reg, (state_reg != IDLE)};
            2'd2:    readdata_next = 32'(last_reg);
            default: readdata_next = timeout_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_cnt_reg  <= '0;
            last_reg     <= '0;
            timeout_reg  <= TIMEOUT_INIT;
            clr_cnt_reg  <= 8'd0;
            sticky_reg   <= 3'b000;
            readdata_reg <= 32'd0;
        end else begin
            run_cnt_reg  <= run_cnt_next;
            last_reg     <= last_next;
            timeout_reg  <= timeout_next;
            clr_cnt_reg  <= clr_cnt_next;
            sticky_reg   <= sticky_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;

`ifdef MNIST_RUN_CTRL_IRQ_EN
    logic irq_en_reg, irq_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_reg <= writedata[8];
            end
            irq_reg <= irq_en_reg & (|sticky_reg);
        end
    end

    assign irq_en = irq_en_reg;
    assign irq    = irq_reg;
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_run_ctrl.sv
// Self-checking bench for mnist_run_ctrl: directed scenarios plus randomized runs checked
// against an outcome model that resolves done/abort/timeout events per RUN cycle.
module tb_mnist_run_ctrl;

    localparam int CLR = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic        eng_clear;
`ifdef MNIST_RUN_CTRL_IRQ_EN
    logic        irq;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   start_pulses = 0;
    logic irq_en_tb = 1'b0;

    always #5 clk = ~clk;

    mnist_run_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_clear  (eng_clear)
`ifdef MNIST_RUN_CTRL_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always @(negedge clk) begin
        if (eng_start) start_pulses++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        address    = 2'd1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_drive(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_drive(a, d);
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
        address = 2'd1;
    endtask

    function automatic logic [31:0] ctrl_word(input int bits);
        return 32'(bits) | (32'(irq_en_tb) << 8);
    endfunction

    // Outcome of a run: kind 1 = done, 2 = abort, 3 = timeout; end_c is the RUN cycle it ends in.
    function automatic void predict(input int done_k, input int abort_k, input int tmo,
                                    input int tw, input int tv,
                                    output int end_c, output int kind);
        end_c = 0;
        kind  = 0;
        for (int c = 1; c <= 1000; c++) begin
            int lim;
            lim = (tw != 0 && c > tw) ? tv : tmo;
            if (c == done_k) begin
                end_c = c; kind = 1; return;
            end
            if (c == abort_k) begin
                end_c = c; kind = 2; return;
            end
            if (lim != 0 && c == lim) begin
                end_c = c; kind = 3; return;
            end
        end
    endfunction

    task automatic run_case(input string name, input int done_k, input int abort_k, input int tmo,
                            input int tw, input int tv, input int sk);
        int          end_c, kind, s0;
        logic [7:0]  ec;
        logic        irq0, irq1;
        logic [31:0] st1, rd, flag, exp_tmo;

        predict(done_k, abort_k, tmo, tw, tv, end_c, kind);
        $display("run %s: done_k=%0d abort_k=%0d tmo=%0d tw=%0d tv=%0d start_k=%0d -> end=%0d kind=%0d",
                 name, done_k, abort_k, tmo, tw, tv, sk, end_c, kind);

        bus_write(2'd3, 32'(tmo));
        s0 = start_pulses;
        bus_drive(2'd0, ctrl_word(1));
        tick();
        check_value({name, "_launch"}, 32'(eng_start), 32'd1);
        bus_idle();
        tick();

        for (int c = 1; c <= end_c; c++) begin
            eng_done = (c == done_k);
            if (c == abort_k)  bus_drive(2'd0, ctrl_word(2));
            else if (c == tw)  bus_drive(2'd3, 32'(tv));
            else if (c == sk)  bus_drive(2'd0, ctrl_word(1));
            tick();
            bus_idle();
            eng_done = 1'b0;
        end

        ec[0] = eng_clear;
        irq0 = 1'b0;
        irq1 = 1'b0;
`ifdef MNIST_RUN_CTRL_IRQ_EN
        irq0 = irq;
`endif
        tick();
        st1 = readdata;
        ec[1] = eng_clear;
`ifdef MNIST_RUN_CTRL_IRQ_EN
        irq1 = irq;
`endif
        for (int j = 2; j < 8; j++) begin
            tick();
            ec[j] = eng_clear;
        end

        flag = (kind == 1) ? 32'h2 : (kind == 2) ? 32'h8 : 32'h4;
        exp_tmo = (tw != 0 && tw <= end_c) ? 32'(tv) : 32'(tmo);
        check_value({name, "_status_early"}, st1, (kind == 1) ? 32'h2 : (flag | 32'h1));
        check_value({name, "_eng_clear"}, 32'(ec), (kind == 1) ? 32'h00 : 32'h0F);
`ifdef MNIST_RUN_CTRL_IRQ_EN
        check_value({name, "_irq_before"}, 32'(irq0), 32'd0);
        check_value({name, "_irq_after"}, 32'(irq1), 32'(irq_en_tb));
`endif
        bus_read(2'd1, rd);
        check_value({name, "_status"}, rd, flag);
        bus_read(2'd2, rd);
        check_value({name, "_last_cycles"}, rd, 32'(end_c));
        bus_read(2'd3, rd);
        check_value({name, "_timeout_reg"}, rd, exp_tmo);
        check_value({name, "_start_pulses"}, 32'(start_pulses - s0), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          s0;

        repeat (3) tick();
        check_value("rst_readdata", readdata, 32'd0);
        check_value("rst_eng_start", 32'(eng_start), 32'd0);
        check_value("rst_eng_clear", 32'(eng_clear), 32'd0);
        reset_n = 1'b1;
        bus_read(2'd0, rd); check_value("rst_ctrl", rd, 32'd0);
        bus_read(2'd1, rd); check_value("rst_status", rd, 32'd0);
        bus_read(2'd2, rd); check_value("rst_last", rd, 32'd0);
        bus_read(2'd3, rd); check_value("rst_timeout", rd, 32'd1000000);

        run_case("basic", 3, 0, 0, 0, 0, 0);
        run_case("timeout", 0, 0, 5, 0, 0, 0);
        run_case("abort", 0, 10, 0, 0, 0, 0);
        run_case("abort_done", 10, 10, 0, 0, 0, 0);
        run_case("busy_start", 8, 0, 0, 0, 0, 3);

        // eng_done in IDLE only shows up in STATUS bit4
        s0 = start_pulses;
        address = 2'd1;
        eng_done = 1'b1;
        tick();
        check_value("idle_done_bit4", readdata, 32'h12);
        eng_done = 1'b0;
        tick();
        check_value("idle_done_gone", readdata, 32'h02);
        check_value("idle_done_no_start", 32'(start_pulses - s0), 32'd0);

        bus_write(2'd0, 32'h100);
`ifdef MNIST_RUN_CTRL_IRQ_EN
        irq_en_tb = 1'b1;
`endif
        bus_read(2'd0, rd);
        check_value("ctrl_irq_en", rd, 32'(irq_en_tb) << 8);
        run_case("basic_irq", 3, 0, 0, 0, 0, 0);
        bus_drive(2'd1, 32'hE);
        tick();
`ifdef MNIST_RUN_CTRL_IRQ_EN
        check_value("w1c_irq_held", 32'(irq), 32'd1);
`endif
        bus_idle();
        tick();
        check_value("w1c_status", readdata, 32'h0);
`ifdef MNIST_RUN_CTRL_IRQ_EN
        check_value("w1c_irq_fall", 32'(irq), 32'd0);
`endif

        run_case("tmo_below", 12, 0, 0, 6, 3, 0);
        run_case("tmo_next", 20, 0, 0, 6, 7, 0);

        for (int r = 0; r < 20; r++) begin
            int dk, ak, tm, tw, tv, sk;
            dk = int'($urandom_range(1, 40));
            ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
            tm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
            tw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
            tv = int'($urandom_range(0, 40));
            sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
            if (tw == ak) tw = 0;
            if (sk == ak || sk == tw) sk = 0;
            run_case($sformatf("rand%0d", r), dk, ak, tm, tw, tv, sk);
        end

        // Reset in the middle of a run
        bus_write(2'd3, 32'd0);
        bus_drive(2'd0, ctrl_word(1));
        tick();
        bus_idle();
        repeat (6) tick();
        reset_n = 1'b0;
        tick();
        check_value("midrst_readdata", readdata, 32'd0);
        check_value("midrst_eng_clear", 32'(eng_clear), 32'd0);
        check_value("midrst_eng_start", 32'(eng_start), 32'd0);
`ifdef MNIST_RUN_CTRL_IRQ_EN
        check_value("midrst_irq", 32'(irq), 32'd0);
`endif
        reset_n = 1'b1;
        irq_en_tb = 1'b0;
        tick();
        check_value("midrst_eng_clear_after", 32'(eng_clear), 32'd0);
        bus_read(2'd3, rd); check_value("midrst_timeout", rd, 32'd1000000);
        bus_read(2'd1, rd); check_value("midrst_status", rd, 32'd0);
        bus_read(2'd2, rd); check_value("midrst_last", rd, 32'd0);
        bus_read(2'd0, rd); check_value("midrst_ctrl", rd, 32'd0);
        run_case("after_reset", 4, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
